fifo_flag_gen: RTL and testbench

- Synchronous FIFO that produces the per-FIFO status flags (almost_full, full, almost_empty, empty) consumed by the flow-control block.
- The flow-control block registers and forwards these flags; this block is their source.
- One instance per FIFO (five in the design).
- rd_en is driven by the flow-control continue/pause output.

---
 rtl/fifo_flag_gen.sv | 113 +++++++++++
 tb/tb_fifo_flag_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flag_gen.sv
// Synchronous FIFO that sources the registered full/almost-full/empty/almost-empty flags.
// Define FIFO_ERR_FLAGS_EN to build the sticky err_ovf/err_udf bits; otherwise both are tied low.
module fifo_flag_gen #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned AF_RST = 3,
    parameter int unsigned AE_RST = 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic              thr_we,
    input  logic [ADDR_W:0]   af_thr,
    input  logic [ADDR_W:0]   ae_thr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic              almost_empty,
    output logic              err_ovf,
    output logic              err_udf
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_n;
    logic [ADDR_W:0]   af_reg;
    logic [ADDR_W:0]   ae_reg;
    logic              wr_acc;
    logic              rd_acc;

    // A write into a full FIFO is still accepted when a read frees the slot on the same edge.
    always_comb begin
        rd_acc  = rd_en & ~empty;
        wr_acc  = wr_en & (~full | rd_acc);
        count_n = count;
        if (wr_acc && !rd_acc) begin
            count_n = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_n = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            af_reg       <= CNT_W'(AF_RST);
            ae_reg       <= CNT_W'(AE_RST);
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + ADDR_W'(1);
                data_out <= mem[rd_ptr];
            end
            valid_out    <= rd_acc;
            count        <= count_n;
            // Flags see the thresholds held before this edge; a load here applies from the next.
            full         <= (count_n == DEPTH_C);
            empty        <= (count_n == '0);
            almost_full  <= (count_n >= af_reg);
            almost_empty <= (count_n <= ae_reg);
            if (thr_we) begin
                af_reg <= af_thr;
                ae_reg <= ae_thr;
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) begin
                err_ovf <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                err_udf <= 1'b1;
            end
        end
    end
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flag_gen.sv
// Self-checking bench for fifo_flag_gen: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based model.
module tb_fifo_flag_gen;

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       thr_we = 1'b0;
    logic [5:0] data_in = '0;
    logic [2:0] af_thr = '0;
    logic [2:0] ae_thr = '0;
    logic [5:0] data_out;
    logic       valid_out, full, almost_full, empty, almost_empty, err_ovf, err_udf;

    int n_cmp = 0;
    int n_fail = 0;

    fifo_flag_gen dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .thr_we       (thr_we),
        .af_thr       (af_thr),
        .ae_thr       (ae_thr),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .err_ovf      (err_ovf),
        .err_udf      (err_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        bit         rd;
        logic [5:0] din;
        bit         full;
        bit         af;
        bit         empty;
        bit         ae;
        bit         valid;
        logic [5:0] dout;
        bit         ovf;
        bit         udf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags(input string tag, input bit f, input bit af, input bit e,
                             input bit ae);
        chk({tag, " full"}, 32'(full), 32'(f));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, " empty"}, 32'(empty), 32'(e));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
    endtask

    task automatic chk_rd(input string tag, input bit v, input logic [5:0] d);
        chk({tag, " valid_out"}, 32'(valid_out), 32'(v));
        chk({tag, " data_out"}, 32'(data_out), 32'(d));
    endtask

    // Drive at the falling edge, sample 1 time unit after the following rising edge.
    task automatic step(input bit w, input bit r, input logic [5:0] d, input bit t,
                        input logic [2:0] a, input logic [2:0] e);
        @(negedge clk);
        wr_en = w; rd_en = r; data_in = d; thr_we = t; af_thr = a; ae_thr = e;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_L = 1'b0;
        wr_en = 0; rd_en = 0; thr_we = 0; data_in = '0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    // Reference model: contents as a queue, thresholds as integers.
    int         m_q[$];
    int         m_af, m_ae;
    logic [5:0] m_dout;
    bit         m_valid, m_ovf, m_udf;

    task automatic model_reset();
        m_q.delete();
        m_af = 3; m_ae = 1; m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_step(input bit w, input bit r, input logic [5:0] d, input bit t,
                              input int a, input int e);
        bit racc, wacc;
        racc = r && (m_q.size() > 0);
        wacc = w && (m_q.size() < 4 || racc);
        m_valid = racc;
        if (racc) m_dout = 6'(m_q.pop_front());
        if (wacc) m_q.push_back(int'(d));
        if (w && !wacc) m_ovf = 1;
        if (r && !racc) m_udf = 1;
        if (t) begin
            m_af = a; m_ae = e;
        end
    endtask

    initial begin
        tbl[0]  = '{1, 0, 6'h01, 0, 0, 0, 1, 0, 6'h00, 0, 0};
        tbl[1]  = '{1, 0, 6'h02, 0, 0, 0, 0, 0, 6'h00, 0, 0};
        tbl[2]  = '{1, 0, 6'h03, 0, 1, 0, 0, 0, 6'h00, 0, 0};
        tbl[3]  = '{1, 0, 6'h04, 1, 1, 0, 0, 0, 6'h00, 0, 0};
        tbl[4]  = '{1, 0, 6'h3F, 1, 1, 0, 0, 0, 6'h00, 1, 0};
        tbl[5]  = '{0, 1, 6'h00, 0, 1, 0, 0, 1, 6'h01, 1, 0};
        tbl[6]  = '{0, 1, 6'h00, 0, 0, 0, 0, 1, 6'h02, 1, 0};
        tbl[7]  = '{0, 1, 6'h00, 0, 0, 0, 1, 1, 6'h03, 1, 0};
        tbl[8]  = '{0, 1, 6'h00, 0, 0, 1, 1, 1, 6'h04, 1, 0};
        tbl[9]  = '{0, 1, 6'h00, 0, 0, 1, 1, 0, 6'h04, 1, 1};
        tbl[10] = '{1, 1, 6'h15, 0, 0, 0, 1, 0, 6'h04, 1, 1};
        tbl[11] = '{0, 1, 6'h00, 0, 0, 1, 1, 1, 6'h15, 1, 1};

        // Reset state
        apply_reset();
        #1;
        chk_flags("reset", 0, 0, 1, 1);
        chk_rd("reset", 0, 6'h00);
        chk("reset err_ovf", 32'(err_ovf), 32'(0));
        chk("reset err_udf", 32'(err_udf), 32'(0));

        // Fill, overflow, drain, underflow, write-into-empty with read
        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].wr, tbl[i].rd, tbl[i].din, 0, '0, '0);
            chk_flags(tag, tbl[i].full, tbl[i].af, tbl[i].empty, tbl[i].ae);
            chk_rd(tag, tbl[i].valid, tbl[i].dout);
            chk({tag, " err_ovf"}, 32'(err_ovf), 32'(ERR_ON & tbl[i].ovf));
            chk({tag, " err_udf"}, 32'(err_udf), 32'(ERR_ON & tbl[i].udf));
        end

        // Simultaneous read/write while full, data order across the pointer wrap
        apply_reset();
        for (int i = 1; i <= 4; i++) step(1, 0, 6'(i), 0, '0, '0);
        chk_flags("sim pre", 1, 1, 0, 0);
        step(1, 1, 6'h2A, 0, '0, '0);
        chk_flags("sim rw", 1, 1, 0, 0);
        chk_rd("sim rw", 1, 6'h01);
        step(0, 1, '0, 0, '0, '0); chk_rd("sim rd1", 1, 6'h02);
        step(0, 1, '0, 0, '0, '0); chk_rd("sim rd2", 1, 6'h03);
        step(0, 1, '0, 0, '0, '0); chk_rd("sim rd3", 1, 6'h04);
        step(0, 1, '0, 0, '0, '0); chk_rd("sim rd4", 1, 6'h2A);
        chk_flags("sim end", 0, 0, 1, 1);

        // Threshold load takes effect one edge later; af=0 forces almost_full
        apply_reset();
        step(0, 0, '0, 1, 3'd2, 3'd0);
        chk_flags("thr load", 0, 0, 1, 1);
        step(1, 0, 6'h11, 0, '0, '0);
        chk_flags("thr wr1", 0, 0, 0, 0);
        step(1, 0, 6'h12, 0, '0, '0);
        chk_flags("thr wr2", 0, 1, 0, 0);
        step(0, 0, '0, 1, 3'd0, 3'd7);
        chk_flags("thr load2", 0, 1, 0, 0);
        step(0, 1, '0, 0, '0, '0);
        step(0, 1, '0, 0, '0, '0);
        chk_flags("thr forced", 0, 1, 1, 1);

        // Asynchronous reset while holding three words
        apply_reset();
        for (int i = 1; i <= 4; i++) step(1, 0, 6'(i + 8), 0, '0, '0);
        step(0, 1, '0, 0, '0, '0);
        chk_rd("async pre", 1, 6'h09);
        #2;
        reset_L = 1'b0;
        #1;
        chk_flags("async", 0, 0, 1, 1);
        chk_rd("async", 0, 6'h00);
        @(negedge clk);
        reset_L = 1'b1;
        step(0, 1, '0, 0, '0, '0);
        chk_rd("async post rd", 0, 6'h00);
        chk_flags("async post", 0, 0, 1, 1);

        // Randomized traffic against the queue model
        apply_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            bit         w, r, t;
            logic [5:0] d;
            int         a, e, n;
            string      tag;
            w = ($urandom_range(0, 99) < (((i / 100) % 2) ? 35 : 70));
            r = ($urandom_range(0, 99) < (((i / 100) % 2) ? 70 : 35));
            t = ($urandom_range(0, 15) == 0);
            d = 6'($urandom);
            a = $urandom_range(0, 7);
            e = $urandom_range(0, 7);
            n = m_q.size();
            model_step(w, r, d, t, a, e);
            step(w, r, d, t, 3'(a), 3'(e));
            // Flags use the thresholds in force before this cycle's load.
            tag = $sformatf("rnd%0d", i);
            chk_flags(tag, m_q.size() == 4, m_q.size() >= (t ? prev_af : m_af),
                      m_q.size() == 0, m_q.size() <= (t ? prev_ae : m_ae));
            chk_rd(tag, m_valid, m_dout);
            chk({tag, " err_ovf"}, 32'(err_ovf), 32'(ERR_ON & m_ovf));
            chk({tag, " err_udf"}, 32'(err_udf), 32'(ERR_ON & m_udf));
            prev_af = m_af;
            prev_ae = m_ae;
            if (n > 4) begin
                n_cmp++;
                n_fail++;
                $display("FAIL model occupancy: got %0d expected <= 4", n);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Thresholds in force before the most recent model_step (tracked across random cycles).
    int prev_af = 3;
    int prev_ae = 1;

endmodule
